// File: rtl/adc_cap_pkg.sv
// Shared constants, state encoding and helpers for the ADC capture readout.
package adc_cap_pkg;

  localparam int DWIDTH     = 256;
  localparam int MAX_XFER   = 2048;
  localparam int CNT_W      = $clog2(MAX_XFER) + 1;
  localparam int ADDR_SHIFT = 5;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_SEQ_LSB = 32;
  localparam int HDR_FLD_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  function automatic logic [31:0] word_addr(input logic [CNT_W-1:0] idx);
    return 32'(idx) << ADDR_SHIFT;
  endfunction

endpackage

// File: rtl/adc_readout_fifo.sv
// Small synchronous FIFO used as the skid buffer behind the BRAM read pipe.
module adc_readout_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rdata = mem[rd_ptr];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/adc_cap_readout.sv
// Reads a finished capture out of BRAM port B and streams it as AXI4-Stream.
// Optional ADC_READOUT_HEADER_EN prepends a {seq, len} header beat.
module adc_cap_readout
  import adc_cap_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [CNT_W-1:0]      len_i,
  input  logic                  cap_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           bram_addr,
  output logic                  bram_en,
  output logic [DWIDTH/8-1:0]   bram_we,
  input  logic [DWIDTH-1:0]     bram_rdata,
  output logic                  bram_clk,
  output logic                  bram_rst,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  state_t                  state;
  logic [CNT_W-1:0]        len_q;
  logic [CNT_W-1:0]        len_in;
  logic [CNT_W-1:0]        rd_idx;
  logic [CNT_W-1:0]        out_cnt;
  logic [FCW-1:0]          inflight;
  logic [FCW-1:0]          count;
  logic [READ_LATENCY-1:0] vld;
  logic [DWIDTH-1:0]       head;
  logic push, pop_data, empty, full;
  logic accept, credit, issue, last_beat, finish;

  assign bram_we  = '0;
  assign bram_clk = clk_i;
  assign bram_rst = rst_i;

  assign len_in    = (len_i > CNT_W'(MAX_XFER)) ? CNT_W'(MAX_XFER) : len_i;
  assign push      = vld[READ_LATENCY-1];
  assign accept    = state == IDLE && start_i && cap_done_i && len_in != '0;
  assign last_beat = out_cnt == len_q - 1'b1;
  assign finish    = state == DRAIN && pop_data && last_beat;

  // A slot freed by this cycle's pop can be re-credited immediately.
  assign credit = (32'(inflight) + 32'(count)) < (FIFO_DEPTH + 32'(pop_data));
  assign issue  = accept || (state == READ && credit);

  adc_readout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DWIDTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (bram_rdata),
    .pop   (pop_data),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

`ifdef ADC_READOUT_HEADER_EN
  logic              hdr_pend;
  logic [31:0]       seq;
  logic [DWIDTH-1:0] hdr_word;

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_LEN_LSB +: HDR_FLD_W] = 32'(len_q);
    hdr_word[HDR_SEQ_LSB +: HDR_FLD_W] = seq;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hdr_pend <= 1'b0;
      seq      <= '0;
    end else begin
      if (accept)             hdr_pend <= 1'b1;
      else if (m_axis_tready) hdr_pend <= 1'b0;
      if (finish) seq <= seq + 1'b1;
    end
  end

  assign m_axis_tvalid = hdr_pend || !empty;
  assign m_axis_tdata  = hdr_pend ? hdr_word : head;
  assign pop_data      = !hdr_pend && !empty && m_axis_tready;
  assign m_axis_tlast  = !hdr_pend && !empty && last_beat;
`else
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = head;
  assign pop_data      = !empty && m_axis_tready;
  assign m_axis_tlast  = !empty && last_beat;
`endif

  // Tags each BRAM pipeline stage; clearing it on reset drops stale reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld <= '0;
    end else begin
      vld[0] <= bram_en;
      for (int k = 1; k < READ_LATENCY; k++) vld[k] <= vld[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      len_q     <= '0;
      rd_idx    <= '0;
      out_cnt   <= '0;
      inflight  <= '0;
    end else begin
      done_o   <= 1'b0;
      bram_en  <= issue;
      inflight <= inflight + FCW'(issue) - FCW'(push);
      if (issue) begin
        bram_addr <= word_addr(rd_idx);
        rd_idx    <= rd_idx + 1'b1;
      end
      if (pop_data) out_cnt <= out_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (accept) begin
            len_q  <= len_in;
            busy_o <= 1'b1;
            state  <= (len_in == CNT_W'(1)) ? DRAIN : READ;
          end else if (start_i && cap_done_i) begin
            done_o <= 1'b1;
          end
        end
        READ: begin
          if (issue && rd_idx == len_q - 1'b1) state <= DRAIN;
        end
        DRAIN: begin
          if (finish) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            rd_idx  <= '0;
            out_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && full && !pop_data));

endmodule

// File: tb/tb_adc_cap_readout.sv
// Directed bench for adc_cap_readout with a behavioural BRAM and a stream monitor.
`timescale 1ns/1ps
module tb_adc_cap_readout;
  import adc_cap_pkg::*;

  localparam int RL = 2;
  localparam int FD = 4;
`ifdef ADC_READOUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_i, start_i, cap_done_i;
  logic [CNT_W-1:0]   len_i;
  logic               busy_o, done_o;
  logic [31:0]        bram_addr;
  logic               bram_en;
  logic [DWIDTH/8-1:0] bram_we;
  logic [DWIDTH-1:0]  bram_rdata;
  logic               bram_clk, bram_rst;
  logic [DWIDTH-1:0]  m_axis_tdata;
  logic               m_axis_tvalid, m_axis_tlast, m_axis_tready;

  adc_cap_readout #(
    .READ_LATENCY (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .len_i         (len_i),
    .cap_done_i    (cap_done_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .bram_addr     (bram_addr),
    .bram_en       (bram_en),
    .bram_we       (bram_we),
    .bram_rdata    (bram_rdata),
    .bram_clk      (bram_clk),
    .bram_rst      (bram_rst),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  function automatic logic [DWIDTH-1:0] word(input int idx);
    logic [DWIDTH-1:0] w;
    for (int j = 0; j < DWIDTH / 32; j++)
      w[32*j +: 32] = {16'(idx), 8'(j), 8'hC3};
    return w;
  endfunction

  // BRAM: address captured on each edge, data presented RL cycles after en.
  logic [31:0] pa [RL];
  always @(posedge clk) begin
    pa[0] <= bram_en ? bram_addr : 32'hFFFF_FFE0;
    for (int k = 1; k < RL; k++) pa[k] <= pa[k-1];
  end
  assign bram_rdata = word(int'(pa[RL-1] >> 5));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Stream / read-port monitor.
  logic              mon_clr = 1'b0;
  int                cur_len = 0;
  int cyc_n = 0, beats, reads, dones, data_err, last_err, stall_err;
  int addr_err, max_out, last_hs_cyc, done_cyc, busy_at_done, busy_seen;
  int hdr_len, hdr_seq;
  logic              held;
  logic [DWIDTH-1:0] held_data;

  always @(negedge clk) begin
    int idx, outst;
    cyc_n++;
    if (mon_clr) begin
      beats = 0; reads = 0; dones = 0; data_err = 0; last_err = 0;
      stall_err = 0; addr_err = 0; max_out = 0; last_hs_cyc = 0;
      done_cyc = 0; busy_at_done = 0; busy_seen = 0;
      hdr_len = -1; hdr_seq = -1; held = 1'b0;
    end else if (rst_i) begin
      held = 1'b0;
    end else begin
      if (held && (!m_axis_tvalid || m_axis_tdata != held_data)) stall_err++;
      held      = m_axis_tvalid && !m_axis_tready;
      held_data = m_axis_tdata;
      if (m_axis_tlast && !m_axis_tvalid) last_err++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (HDR == 1 && beats == 0) begin
          hdr_len = int'(m_axis_tdata[31:0]);
          hdr_seq = int'(m_axis_tdata[63:32]);
          if (m_axis_tlast || m_axis_tdata[DWIDTH-1:64] != '0) data_err++;
        end else begin
          idx = beats - HDR;
          if (m_axis_tdata != word(idx)) data_err++;
          if (m_axis_tlast != (idx == cur_len - 1)) last_err++;
        end
        beats++;
        last_hs_cyc = cyc_n;
      end
      if (bram_en) begin
        if (bram_addr != (32'(reads) << 5)) addr_err++;
        reads++;
      end
      outst = reads - (beats - ((HDR == 1 && beats > 0) ? 1 : 0));
      if (outst > max_out) max_out = outst;
      if (busy_o) busy_seen = 1;
      if (done_o) begin
        dones++;
        done_cyc     = cyc_n;
        busy_at_done = int'(busy_o);
      end
    end
  end

  typedef struct {
    int len;
    bit cap;
    int mode;       // 0 ready high, 1 random, 2 low for 'stall' cycles
    int stall;
    int exp_beats;
    int exp_reads;
    int exp_dones;
    int exp_lat;    // edges from accept to first tvalid, -1 = unchecked
  } vec_t;

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic run(input vec_t v, input string tag);
    int cyc, budget, first_tv;
    cur_len = (v.len > MAX_XFER) ? MAX_XFER : v.len;
    clear_mon();
    len_i = CNT_W'(v.len);
    cap_done_i = v.cap;
    m_axis_tready = (v.mode == 2) ? 1'b0 : 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    budget = 4 * cur_len + 60;
    cyc = 0;
    first_tv = -1;
    while (cyc < budget && !(v.exp_dones > 0 && dones > 0)) begin
      if (first_tv < 0 && m_axis_tvalid) first_tv = cyc;
      if (v.mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
      else if (v.mode == 2) m_axis_tready = (cyc >= v.stall);
      if (v.mode == 2 && cyc == v.stall - 1)
        chk({tag, " reads_while_stalled"}, reads, FD);
      @(posedge clk);
      #1 cyc++;
    end
    m_axis_tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    if (v.exp_lat >= 0) chk({tag, " first_tvalid_latency"}, first_tv, v.exp_lat);
    chk({tag, " beats"}, beats, v.exp_beats);
    chk({tag, " reads"}, reads, v.exp_reads);
    chk({tag, " done_pulses"}, dones, v.exp_dones);
    chk({tag, " data_errors"}, data_err, 0);
    chk({tag, " tlast_errors"}, last_err, 0);
    chk({tag, " stall_errors"}, stall_err, 0);
    chk({tag, " addr_errors"}, addr_err, 0);
    chk({tag, " outstanding_le_depth"}, max_out <= FD, 1);
    chk({tag, " busy_seen"}, busy_seen, v.exp_reads > 0);
    chk({tag, " busy_end"}, busy_o, 0);
    chk({tag, " tvalid_end"}, m_axis_tvalid, 0);
    if (v.exp_beats > 0) begin
      chk({tag, " done_after_last"}, done_cyc - last_hs_cyc, 1);
      chk({tag, " busy_at_done"}, busy_at_done, 0);
    end
  endtask

  vec_t vt[8];

  initial begin
    int n, b0, d0;
    vt[0] = '{16,   1, 0, 0,  16 + HDR,   16,   1, HDR == 1 ? 0 : RL + 1};
    vt[1] = '{8,    1, 2, 20, 8 + HDR,    8,    1, -1};
    vt[2] = '{0,    1, 0, 0,  0,          0,    1, -1};
    vt[3] = '{5,    0, 0, 0,  0,          0,    0, -1};
    vt[4] = '{1,    1, 1, 0,  1 + HDR,    1,    1, -1};
    vt[5] = '{2048, 1, 1, 0,  2048 + HDR, 2048, 1, -1};
    vt[6] = '{3000, 1, 0, 0,  2048 + HDR, 2048, 1, -1};
    vt[7] = '{4,    1, 0, 0,  4 + HDR,    4,    1, -1};

    len_i = '0;
    cap_done_i = 1'b1;
    m_axis_tready = 1'b1;
    do_reset();
    chk("reset busy_o", busy_o, 0);
    chk("reset done_o", done_o, 0);
    chk("reset bram_en", bram_en, 0);
    chk("reset bram_addr", bram_addr, 0);
    chk("reset tvalid", m_axis_tvalid, 0);
    chk("reset tlast", m_axis_tlast, 0);

    for (int i = 0; i < 7; i++) run(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a 32-word readout.
    cur_len = 32;
    clear_mon();
    len_i = CNT_W'(32);
    cap_done_i = 1'b1;
    m_axis_tready = 1'b1;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    n = 0;
    while (beats < 5 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk("midrst reached_5_beats", beats >= 5, 1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst busy_o", busy_o, 0);
    chk("midrst done_o", done_o, 0);
    chk("midrst bram_en", bram_en, 0);
    chk("midrst bram_addr", bram_addr, 0);
    chk("midrst tvalid", m_axis_tvalid, 0);
    chk("midrst tlast", m_axis_tlast, 0);
    rst_i = 1'b0;
    b0 = beats;
    d0 = dones;
    repeat (12) @(posedge clk);
    #1;
    chk("midrst no_stale_beats", beats - b0, 0);
    chk("midrst no_done", dones - d0, 0);
    chk("midrst idle_tvalid", m_axis_tvalid, 0);
    run(vt[7], "after_rst");

`ifdef ADC_READOUT_HEADER_EN
    do_reset();
    for (int k = 0; k < 2; k++) begin
      run('{3, 1, 0, 0, 4, 3, 1, -1}, $sformatf("hdr%0d", k));
      chk($sformatf("hdr%0d len_field", k), hdr_len, 3);
      chk($sformatf("hdr%0d seq_field", k), hdr_seq, k);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adc_cap_readout.md
Name: adc_cap_readout

Overview:
- Downstream consumer of the ADC capture buffer.
- After the capture stage asserts its done flag, reads N 256-bit words from the capture BRAM's second port and streams them out as AXI4-Stream with TLAST on the final beat.
- Absorbs the BRAM's fixed read latency with a small credit-controlled skid FIFO, so full downstream backpressure never loses or duplicates a word.
- Feeds the DMA/packetizer toward the PS.

Parameters:
- DWIDTH, 256, BRAM word and stream data width (bits).
- MAX_XFER, 2048, capture depth in words; power of 2.
- READ_LATENCY, 2, BRAM read latency in cycles (en to rdata valid); legal range 1..3.
- FIFO_DEPTH, 4, skid FIFO entries; must be >= READ_LATENCY+1 and a power of 2.

Ports:
- clk_i  in  1  single clock for BRAM port B and stream.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle request to read out; honoured only in IDLE.
- len_i  in  $clog2(MAX_XFER)+1  word count; sampled on accepted start; valid 0..MAX_XFER.
- cap_done_i  in  1  high while the capture stage is idle (buffer stable).
- busy_o  out  1  high from accepted start until last beat handshaken.
- done_o  out  1  one-cycle pulse after the last beat (or immediately for len 0).
- bram_addr  out  32  byte address = word_index << 5.
- bram_en  out  1  read enable.
- bram_we  out  DWIDTH/8  tied 0.
- bram_rdata  in  DWIDTH  read data, valid READ_LATENCY cycles after bram_en.
- bram_clk  out  1  = clk_i.
- bram_rst  out  1  = rst_i.
- m_axis_tdata  out  DWIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tlast  out  1  high on the final beat.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset values: busy_o=0, done_o=0, bram_en=0, bram_addr=0, m_axis_tvalid=0, m_axis_tlast=0, FIFO empty, state IDLE.
- Reset mid-transfer aborts immediately:
  - No done_o pulse.
  - Data already in the BRAM pipeline is discarded via a per-stage valid shift register that is cleared on reset.
- State IDLE:
  - If start_i && cap_done_i && len_i!=0: latch len, rd_idx=0, out_cnt=0, go to READ.
  - If start_i && cap_done_i && len_i==0: pulse done_o the next cycle, stay IDLE.
  - If start_i while !cap_done_i: ignored (no latch, no pulse).
  - len_i > MAX_XFER: clamp to MAX_XFER.
- State READ:
  - Issue a read (bram_en=1, bram_addr=rd_idx<<5) only when inflight + fifo_count < FIFO_DEPTH.
  - inflight counts issued reads whose data is not yet in the FIFO.
  - rd_idx increments per issued read.
  - After issuing read len-1, go to DRAIN.
- State DRAIN:
  - No further reads.
  - Exit to IDLE when the beat with out_cnt==len-1 is handshaken.
  - done_o pulses 1 cycle after that handshake; busy_o falls in the same cycle done_o rises.
- Pipeline:
  - bram_rdata is written into the FIFO exactly READ_LATENCY cycles after its bram_en.
  - The credit rule guarantees the FIFO never overflows; overflow is an assertion failure.
- Stream:
  - m_axis_tvalid = FIFO not empty; m_axis_tdata = FIFO head.
  - m_axis_tlast = (out_cnt == len-1) && tvalid.
  - Pop on tvalid && tready.
  - tvalid must not drop and tdata must not change while tready is low.
- Latency: with tready held high, first tvalid appears READ_LATENCY+1 cycles after start_i; steady state is 1 beat/cycle.
- Counters: rd_idx and out_cnt are $clog2(MAX_XFER)+1 bits; no wrap for len==MAX_XFER.
- Simultaneous FIFO push and pop in one cycle leaves the count unchanged.

Optional Feature:
- Macro ADC_READOUT_HEADER_EN.
- When defined:
  - One header beat precedes the data beats.
  - Header tdata[31:0] = len, tdata[63:32] = 32-bit readout sequence number (increments per completed readout, reset to 0); upper bits 0.
  - Header never carries tlast; tlast placement on data beats is unchanged; for len 0 no header is sent.
- When undefined: no header beat, no sequence counter logic.

Decomposition:
- Shared package (adc_cap_pkg): DWIDTH, MAX_XFER, address shift (5), state enum {IDLE, READ, DRAIN}, header field offsets.
- One sub-module: adc_readout_fifo, a synchronous FIFO with parameterised depth and width, providing count, empty and full.

Test Plan:
- len=16, tready=1, cap_done=1 → 16 beats with data = BRAM[0..15], tlast only on beat 15, done_o pulse 1 cycle after beat 15, reads at addrs 0x000..0x1E0.
- len=2048, tready toggled random 50% → exactly 2048 beats in order, no duplicates or gaps, FIFO count never exceeds 4, tdata stable while stalled.
- tready=0 for 20 cycles after start, len=8 → exactly FIFO_DEPTH reads issued then bram_en stays low; release → 8 correct beats.
- start_i with cap_done_i=0 → busy_o stays 0, no bram_en; len=0 with cap_done_i=1 → done_o pulse, no tvalid.
- rst_i asserted after 5 of 32 beats → all outputs at reset values next cycle, no done_o, no stale beats; new start len=4 → 4 beats from address 0.
- ADC_READOUT_HEADER_EN, two readouts of len=3 → header beats with tdata[31:0]=3, seq 0 then 1, followed by 3 data beats each, tlast on the 3rd data beat.
